// File: rtl/port_req_retry_if.sv
// rtl/port_req_retry_if.sv - queue/arbiter/read-engine signal bundle for port_req_retry
interface port_req_retry_if #(
  parameter int PORTNUM = 16
);
  localparam int PW = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;

  logic               i_que_vld;
  logic               i_empty;
  logic [PORTNUM-1:0] i_port_ready;
  logic [PORTNUM-1:0] i_resp;
  logic [PORTNUM-1:0] i_nresp;
  logic [PW-1:0]      i_port;
  logic               i_port_vld;
  logic               i_r_finish;
  logic               o_update;
  logic               o_port_vld;
  logic [PW-1:0]      o_port;
  logic               o_clr_vld;
  logic [PW-1:0]      o_clr_port;
  logic [PORTNUM-1:0] o_req;
  logic               o_busy;
  logic               o_timeout;

  // Controller view
  modport master (
    input  i_que_vld, i_empty, i_port_ready, i_resp, i_nresp,
           i_port, i_port_vld, i_r_finish,
    output o_update, o_port_vld, o_port, o_clr_vld, o_clr_port,
           o_req, o_busy, o_timeout
  );

  // Queue manager / arbiter / read engine view
  modport slave (
    output i_que_vld, i_empty, i_port_ready, i_resp, i_nresp,
           i_port, i_port_vld, i_r_finish,
    input  o_update, o_port_vld, o_port, o_clr_vld, o_clr_port,
           o_req, o_busy, o_timeout
  );
endinterface

// File: rtl/port_req_retry.sv
// rtl/port_req_retry.sv - per-input-port request controller with bounded retry and transfer timeout
module port_req_retry #(
  parameter int PORTNUM      = 16,
  parameter int RETRY_MAX    = 4,
  parameter int WAIT_CYC     = 8,
  parameter int XFER_TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  port_req_retry_if.master bus
);
  localparam int PW = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;
  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam int WW = $clog2(WAIT_CYC + 1);
  localparam int XW = $clog2(XFER_TIMEOUT);

  localparam logic [PW:0]         PORT_LIMIT = (PW + 1)'(PORTNUM);
  localparam logic [RW-1:0]       RETRY_LAST = RW'(RETRY_MAX);
  localparam logic [WW-1:0]       WAIT_LAST  = WW'(WAIT_CYC - 1);
  localparam logic [XW-1:0]       XFER_LAST  = XW'(XFER_TIMEOUT - 1);
  localparam logic [PORTNUM-1:0]  ONE_HOT0   = PORTNUM'(1);

  typedef enum logic [2:0] {
    IDLE, UPDATE, GETPORT, REQ, WAIT, CLR, XFER
  } state_t;

  state_t        state, next_state;
  logic [PW-1:0] port;
  logic [RW-1:0] retry_cnt;
  logic [WW-1:0] wait_cnt;
  logic [XW-1:0] xfer_cnt;

  logic port_ok;
  logic load_port;
  logic wait_last;
  logic xfer_last;

  // Out-of-range indices (non power-of-two PORTNUM) are never requested
  assign port_ok   = ({1'b0, port} < PORT_LIMIT) && bus.i_port_ready[port];
  assign load_port = bus.i_port_vld && (state == UPDATE || state == CLR);
  assign wait_last = (wait_cnt == WAIT_LAST);
  assign xfer_last = (xfer_cnt == XFER_LAST);

  // Next-state selection; outputs below are decoded from it so they line up with the new state
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.i_que_vld) next_state = UPDATE;
      UPDATE:  if (bus.i_port_vld) next_state = GETPORT;
      GETPORT: next_state = port_ok ? REQ : CLR;
      REQ:     next_state = WAIT;
      WAIT: begin
        if (bus.i_resp[port])       next_state = XFER;
        else if (bus.i_nresp[port]) next_state = CLR;
        else if (wait_last)         next_state = (retry_cnt == RETRY_LAST) ? CLR : REQ;
      end
      CLR: begin
        if (bus.i_port_vld)   next_state = GETPORT;
        else if (bus.i_empty) next_state = IDLE;
      end
      XFER:    if (bus.i_r_finish || xfer_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, latched port, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      port           <= '0;
      retry_cnt      <= '0;
      wait_cnt       <= '0;
      xfer_cnt       <= '0;
      bus.o_update   <= 1'b0;
      bus.o_port_vld <= 1'b0;
      bus.o_port     <= '0;
      bus.o_clr_vld  <= 1'b0;
      bus.o_clr_port <= '0;
      bus.o_req      <= '0;
      bus.o_busy     <= 1'b0;
      bus.o_timeout  <= 1'b0;
    end else begin
      state <= next_state;

      if (load_port) port <= bus.i_port;

      if (state == GETPORT)  retry_cnt <= '0;
      else if (state == REQ) retry_cnt <= retry_cnt + RW'(1);

      if (state == REQ)                              wait_cnt <= '0;
      else if (state == WAIT && next_state == WAIT)  wait_cnt <= wait_cnt + WW'(1);

      if (state != XFER)           xfer_cnt <= '0;
      else if (next_state == XFER) xfer_cnt <= xfer_cnt + XW'(1);

      // Pulses fire only on entry, so a stay never repeats them
      bus.o_update   <= (next_state == UPDATE) && (state != UPDATE);
      bus.o_port_vld <= (next_state == XFER) && (state != XFER);
      bus.o_port     <= (next_state == XFER && state != XFER) ? port : '0;
      bus.o_clr_vld  <= (next_state == CLR) && (state != CLR);
      bus.o_clr_port <= (next_state == CLR && state != CLR) ? port : '0;
      bus.o_req      <= (next_state == REQ) ? (ONE_HOT0 << port) : '0;
      bus.o_busy     <= (next_state != IDLE);
      bus.o_timeout  <= (state == XFER) && !bus.i_r_finish && xfer_last;
    end
  end
endmodule

// File: tb/tb_port_req_retry.sv
// tb/tb_port_req_retry.sv - self-checking bench for port_req_retry
module tb_port_req_retry;
  localparam int PN = 16;
  localparam int RM = 2;
  localparam int WC = 3;
  localparam int XT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  port_req_retry_if #(.PORTNUM(PN)) bus ();

  port_req_retry #(
    .PORTNUM(PN), .RETRY_MAX(RM), .WAIT_CYC(WC), .XFER_TIMEOUT(XT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [28:0] obs;
  assign obs = {bus.o_update, bus.o_port_vld, bus.o_port, bus.o_clr_vld,
                bus.o_clr_port, bus.o_req, bus.o_busy, bus.o_timeout};

  // Expected output word: update, port_vld, port, clr_vld, clr_port, req, busy, timeout
  function automatic logic [28:0] ev(input bit upd, input bit pv, input int pp, input bit cv,
                                     input int cp, input logic [15:0] rq, input bit bsy, input bit to);
    return {upd, pv, 4'(pp), cv, 4'(cp), rq, bsy, to};
  endfunction

  function automatic logic [15:0] oh(input int p);
    logic [15:0] one;
    one = 16'd1;
    return one << p;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [28:0] e);
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // One queue transaction from IDLE back to IDLE, expected timeline derived from
  // the retry/wait/timeout arithmetic. kind: 0 grant, 1 refusal, 2 silence.
  task automatic txn(input string tag, input int p, input bit rdy, input int kind,
                     input int att, input int off, input int fin, input int nxt);
    logic [15:0] m;
    bit hit;
    bit done;
    int n_req;
    m = oh(p);
    bus.i_que_vld = 1'b1;
    cyc();
    bus.i_que_vld = 1'b0;
    chk({tag, ":update"}, ev(1, 0, 0, 0, 0, 16'h0, 1, 0));
    bus.i_port       = 4'(p);
    bus.i_port_vld   = 1'b1;
    bus.i_port_ready = rdy ? (16'($urandom) | m) : (16'($urandom) & ~m);
    cyc();
    bus.i_port_vld = 1'b0;
    bus.i_port     = 4'($urandom);
    chk({tag, ":getport"}, ev(0, 0, 0, 0, 0, 16'h0, 1, 0));
    hit = 1'b0;
    if (rdy) begin
      n_req = (kind == 2) ? RM : att + 1;
      for (int a = 0; a < n_req && !hit; a++) begin
        cyc();
        chk({tag, ":req"}, ev(0, 0, 0, 0, 0, m, 1, 0));
        for (int w = 0; w < WC && !hit; w++) begin
          cyc();
          chk({tag, ":wait"}, ev(0, 0, 0, 0, 0, 16'h0, 1, 0));
          bus.i_resp     = 16'($urandom) & ~m;
          bus.i_nresp    = 16'($urandom) & ~m;
          bus.i_port_vld = 1'($urandom);
          bus.i_port     = 4'($urandom);
          if (kind != 2 && a == att && w == off) begin
            hit = 1'b1;
            if (kind == 0) begin
              bus.i_resp = bus.i_resp | m;
              if ($urandom_range(0, 1) == 1) bus.i_nresp = bus.i_nresp | m;
            end else begin
              bus.i_nresp = bus.i_nresp | m;
            end
          end
        end
      end
    end
    cyc();
    bus.i_resp     = '0;
    bus.i_nresp    = '0;
    bus.i_port_vld = 1'b0;
    if (rdy && kind == 0) begin
      chk({tag, ":xfer"}, ev(0, 1, p, 0, 0, 16'h0, 1, 0));
      done = 1'b0;
      for (int c = 1; c <= XT && !done; c++) begin
        bus.i_port_vld = 1'($urandom);
        bus.i_port     = 4'($urandom);
        if (c == fin) begin
          bus.i_r_finish = 1'b1;
          cyc();
          bus.i_r_finish = 1'b0;
          bus.i_port_vld = 1'b0;
          chk({tag, ":finish"}, ev(0, 0, 0, 0, 0, 16'h0, 0, 0));
          done = 1'b1;
        end else if (c == XT) begin
          cyc();
          bus.i_port_vld = 1'b0;
          chk({tag, ":timeout"}, ev(0, 0, 0, 0, 0, 16'h0, 0, 1));
          cyc();
          chk({tag, ":post_timeout"}, ev(0, 0, 0, 0, 0, 16'h0, 0, 0));
          done = 1'b1;
        end else begin
          cyc();
          chk({tag, ":xfer_hold"}, ev(0, 0, 0, 0, 0, 16'h0, 1, 0));
        end
      end
    end else begin
      chk({tag, ":clr"}, ev(0, 0, 0, 1, p, 16'h0, 1, 0));
      if (nxt >= 0) begin
        bus.i_port       = 4'(nxt);
        bus.i_port_vld   = 1'b1;
        bus.i_empty      = 1'b1;
        bus.i_port_ready = bus.i_port_ready & ~oh(nxt);
        cyc();
        bus.i_port_vld = 1'b0;
        bus.i_empty    = 1'b0;
        chk({tag, ":chain_getport"}, ev(0, 0, 0, 0, 0, 16'h0, 1, 0));
        cyc();
        chk({tag, ":chain_clr"}, ev(0, 0, 0, 1, nxt, 16'h0, 1, 0));
      end
      repeat ($urandom_range(0, 2)) begin
        cyc();
        chk({tag, ":clr_hold"}, ev(0, 0, 0, 0, 0, 16'h0, 1, 0));
      end
      bus.i_empty = 1'b1;
      cyc();
      bus.i_empty = 1'b0;
      chk({tag, ":idle"}, ev(0, 0, 0, 0, 0, 16'h0, 0, 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_que_vld    = 1'b0;
    bus.i_empty      = 1'b0;
    bus.i_port_ready = '0;
    bus.i_resp       = '0;
    bus.i_nresp      = '0;
    bus.i_port       = '0;
    bus.i_port_vld   = 1'b0;
    bus.i_r_finish   = 1'b0;

    rst_n = 1'b0;
    cyc();
    cyc();
    chk("reset", ev(0, 0, 0, 0, 0, 16'h0, 0, 0));
    rst_n = 1'b1;
    cyc();
    chk("reset_idle", ev(0, 0, 0, 0, 0, 16'h0, 0, 0));

    txn("grant",      5, 1'b1, 0, 0, 0, 1,      -1);
    txn("exhaust",    3, 1'b1, 2, 0, 0, 1,      -1);
    txn("refuse",     7, 1'b1, 1, 0, 1, 1,       9);
    txn("notready",   2, 1'b0, 0, 0, 0, 1,      -1);
    txn("timeout",   11, 1'b1, 0, 1, 2, XT + 1, -1);
    txn("fin_at_to", 12, 1'b1, 0, 0, 2, XT,     -1);

    bus.i_que_vld = 1'b1;
    cyc();
    bus.i_que_vld = 1'b0;
    chk("mid:update", ev(1, 0, 0, 0, 0, 16'h0, 1, 0));
    bus.i_port       = 4'd4;
    bus.i_port_vld   = 1'b1;
    bus.i_port_ready = 16'h0010;
    cyc();
    bus.i_port_vld = 1'b0;
    chk("mid:getport", ev(0, 0, 0, 0, 0, 16'h0, 1, 0));
    cyc();
    chk("mid:req", ev(0, 0, 0, 0, 0, 16'h0010, 1, 0));
    cyc();
    chk("mid:wait", ev(0, 0, 0, 0, 0, 16'h0, 1, 0));
    rst_n = 1'b0;
    cyc();
    chk("mid:reset", ev(0, 0, 0, 0, 0, 16'h0, 0, 0));
    rst_n = 1'b1;
    cyc();
    chk("mid:idle", ev(0, 0, 0, 0, 0, 16'h0, 0, 0));
    txn("restart", 4, 1'b1, 0, 0, 0, 3, -1);

    for (int i = 0; i < 40; i++) begin
      txn($sformatf("rnd%0d", i),
          $urandom_range(0, PN - 1),
          ($urandom_range(0, 3) != 0),
          $urandom_range(0, 2),
          $urandom_range(0, RM - 1),
          $urandom_range(0, WC - 1),
          $urandom_range(1, XT + 1),
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, PN - 1) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
